// File: rtl/blackjack_round_ctrl_pkg.sv
// Shared definitions for the blackjack round sequencer: state and result
// encodings plus the default game thresholds.
package blackjack_round_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DEAL_P1 = 4'd1,
        ST_DEAL_D1 = 4'd2,
        ST_DEAL_P2 = 4'd3,
        ST_PLAYER  = 4'd4,
        ST_P_HIT   = 4'd5,
        ST_DEALER  = 4'd6,
        ST_D_HIT   = 4'd7,
        ST_RESOLVE = 4'd8,
        ST_DONE    = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_PLAYER = 2'b01,
        RES_DEALER = 2'b10,
        RES_PUSH   = 2'b11
    } result_e;

    localparam int TARGET_DEFAULT       = 21;
    localparam int DEALER_STAND_DEFAULT = 17;

endpackage

// File: rtl/blackjack_round_ctrl_button_edge_sync.sv
// Two-flop synchroniser for an active-low pushbutton followed by a registered
// falling-edge detector; a held button yields a single one-cycle pulse.
module button_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        // Released-to-pressed transition of the synchronised level
        pulse_d = prev_q & ~sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign press = pulse_q;

endmodule

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: deals from a shared req/ack card source, runs the
// player's hit/stand and the dealer's automatic draw, then scores the round.
module blackjack_round_ctrl
    import blackjack_round_ctrl_pkg::*;
#(
    parameter int CARD_W       = 4,
    parameter int HAND_W       = 5,
    parameter int TARGET       = TARGET_DEFAULT,
    parameter int DEALER_STAND = DEALER_STAND_DEFAULT
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              enter_n,
    input  logic              pass_n,
    input  logic              card_ack,
    input  logic [CARD_W-1:0] card_val,
    output logic              card_req,
    output logic              card_to_dealer,
    output logic [HAND_W-1:0] phand,
    output logic [HAND_W-1:0] dhand,
    output logic [1:0]        result,
    output logic              busy,
    output logic [3:0]        state_out
);

    localparam logic [HAND_W-1:0] TGT       = HAND_W'(TARGET);
    localparam logic [HAND_W-1:0] STAND     = HAND_W'(DEALER_STAND);
    localparam logic [HAND_W-1:0] ACE_LIMIT = HAND_W'(TARGET - 10);

    // Rank 0 reads as an ace; anything above ten is a face card.
    function automatic logic [HAND_W-1:0] norm_card(input logic [CARD_W-1:0] v);
        if (v == '0) begin
            return HAND_W'(1);
        end else if (v > CARD_W'(10)) begin
            return HAND_W'(10);
        end
        return HAND_W'(v);
    endfunction

    function automatic logic [HAND_W-1:0] eff_total(input logic [HAND_W-1:0] hard,
                                                    input logic              ace);
        if (ace && (hard <= ACE_LIMIT)) begin
            return hard + HAND_W'(10);
        end
        return hard;
    endfunction

    // Returns {ace_flag, hard_sum} after adding one normalised card.
    function automatic logic [HAND_W:0] hand_add(input logic [HAND_W-1:0] hard,
                                                 input logic              ace,
                                                 input logic [HAND_W-1:0] card);
        return {ace | (card == HAND_W'(1)), hard + card};
    endfunction

    logic press_enter;
    logic press_pass;

    button_edge_sync u_enter_sync (
        .clk   (Clock),
        .rst   (reset),
        .btn_n (enter_n),
        .press (press_enter)
    );

    button_edge_sync u_pass_sync (
        .clk   (Clock),
        .rst   (reset),
        .btn_n (pass_n),
        .press (press_pass)
    );

    state_e              state_q,    state_d;
    logic [HAND_W-1:0]   p_hard_q,   p_hard_d;
    logic                p_ace_q,    p_ace_d;
    logic [HAND_W-1:0]   d_hard_q,   d_hard_d;
    logic                d_ace_q,    d_ace_d;
    result_e             result_q,   result_d;
    logic                card_req_q, card_req_d;

    logic [HAND_W-1:0]   card_n;
    logic [HAND_W:0]     p_sum;
    logic [HAND_W:0]     d_sum;
    logic [HAND_W-1:0]   p_eff;
    logic [HAND_W-1:0]   d_eff;
    logic [HAND_W-1:0]   p_new_eff;
    logic                take;

    always_comb begin
        card_n    = norm_card(card_val);
        p_sum     = hand_add(p_hard_q, p_ace_q, card_n);
        d_sum     = hand_add(d_hard_q, d_ace_q, card_n);
        p_eff     = eff_total(p_hard_q, p_ace_q);
        d_eff     = eff_total(d_hard_q, d_ace_q);
        p_new_eff = eff_total(p_sum[HAND_W-1:0], p_sum[HAND_W]);
        // An ack only counts while a request is outstanding.
        take      = card_req_q & card_ack;
    end

    always_comb begin
        state_d    = state_q;
        p_hard_d   = p_hard_q;
        p_ace_d    = p_ace_q;
        d_hard_d   = d_hard_q;
        d_ace_d    = d_ace_q;
        result_d   = result_q;
        card_req_d = card_req_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (press_enter) begin
                    p_hard_d   = '0;
                    p_ace_d    = 1'b0;
                    d_hard_d   = '0;
                    d_ace_d    = 1'b0;
                    result_d   = RES_NONE;
                    card_req_d = 1'b1;
                    state_d    = ST_DEAL_P1;
                end
            end

            ST_DEAL_P1: begin
                if (!card_req_q) begin
                    card_req_d = 1'b1;
                end else if (take) begin
                    {p_ace_d, p_hard_d} = p_sum;
                    card_req_d = 1'b0;
                    state_d    = ST_DEAL_D1;
                end
            end

            // Back-to-back deals leave one idle cycle on card_req between cards.
            ST_DEAL_D1: begin
                if (!card_req_q) begin
                    card_req_d = 1'b1;
                end else if (take) begin
                    {d_ace_d, d_hard_d} = d_sum;
                    card_req_d = 1'b0;
                    state_d    = ST_DEAL_P2;
                end
            end

            ST_DEAL_P2: begin
                if (!card_req_q) begin
                    card_req_d = 1'b1;
                end else if (take) begin
                    {p_ace_d, p_hard_d} = p_sum;
                    card_req_d = 1'b0;
                    state_d    = (p_new_eff == TGT) ? ST_DEALER : ST_PLAYER;
                end
            end

            ST_PLAYER: begin
                if (press_enter) begin
                    card_req_d = 1'b1;
                    state_d    = ST_P_HIT;
                end else if (press_pass) begin
                    state_d = ST_DEALER;
                end
            end

            ST_P_HIT: begin
                if (!card_req_q) begin
                    card_req_d = 1'b1;
                end else if (take) begin
                    {p_ace_d, p_hard_d} = p_sum;
                    card_req_d = 1'b0;
                    if (p_new_eff > TGT) begin
                        state_d = ST_RESOLVE;
                    end else if (p_new_eff == TGT) begin
                        state_d = ST_DEALER;
                    end else begin
                        state_d = ST_PLAYER;
                    end
                end
            end

            ST_DEALER: begin
                if (d_eff < STAND) begin
                    card_req_d = 1'b1;
                    state_d    = ST_D_HIT;
                end else begin
                    state_d = ST_RESOLVE;
                end
            end

            ST_D_HIT: begin
                if (!card_req_q) begin
                    card_req_d = 1'b1;
                end else if (take) begin
                    {d_ace_d, d_hard_d} = d_sum;
                    card_req_d = 1'b0;
                    state_d    = ST_DEALER;
                end
            end

            ST_RESOLVE: begin
                if (p_eff > TGT) begin
                    result_d = RES_DEALER;
                end else if (d_eff > TGT) begin
                    result_d = RES_PLAYER;
                end else if (p_eff > d_eff) begin
                    result_d = RES_PLAYER;
                end else if (p_eff < d_eff) begin
                    result_d = RES_DEALER;
                end else begin
                    result_d = RES_PUSH;
                end
                state_d = ST_DONE;
            end

            default: begin
                card_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            p_hard_q   <= '0;
            p_ace_q    <= 1'b0;
            d_hard_q   <= '0;
            d_ace_q    <= 1'b0;
            result_q   <= RES_NONE;
            card_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_hard_q   <= p_hard_d;
            p_ace_q    <= p_ace_d;
            d_hard_q   <= d_hard_d;
            d_ace_q    <= d_ace_d;
            result_q   <= result_d;
            card_req_q <= card_req_d;
        end
    end

    assign card_req       = card_req_q;
    assign card_to_dealer = (state_q == ST_DEAL_D1) || (state_q == ST_D_HIT);
    assign phand          = p_eff;
    assign dhand          = d_eff;
    assign result         = result_q;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign state_out      = state_q;

endmodule

// File: doc/blackjack_round_ctrl.md
Name: blackjack_round_ctrl

Overview:
- Round sequencer for the blackjack game. Owns the player and dealer hand registers and drives the shared card source through a req/ack handshake.
- Deals the opening cards, then services player hit/stand from the enter/pass pushbuttons.
- Runs the dealer's automatic draw, then resolves the outcome.
- Sits between the debounced board pushbuttons/random card source and the LED/HEX display logic.

Parameters:
- CARD_W, 4, width of card value from source
- HAND_W, 5, width of hand totals
- TARGET, 21, bust threshold / blackjack total
- DEALER_STAND, 17, dealer stops drawing at effective total >= this

Ports:
- Clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enter_n  in  1  active-low pushbutton: start round / hit
- pass_n  in  1  active-low pushbutton: stand
- card_ack  in  1  card source has valid card_val this cycle
- card_val  in  CARD_W  card rank, 1=ace, 2..10
- card_req  out  1  request one card from the shared source
- card_to_dealer  out  1  destination of current request (0 player, 1 dealer)
- phand  out  HAND_W  player effective total
- dhand  out  HAND_W  dealer effective total
- result  out  2  00 none, 01 player win, 10 dealer win, 11 push
- busy  out  1  high in every state except IDLE and DONE
- state_out  out  4  current state encoding, for debug LEDs

Behaviour:
- Reset (async, active-high): state=IDLE. Outputs phand=0, dhand=0, result=00, card_req=0, card_to_dealer=0, busy=0. Hard sums and ace flags are cleared. Button synchronisers are set to released (1).
- Buttons: each button passes through a 2-FF synchroniser and a falling-edge detector, giving a one-cycle press pulse. A held button produces exactly one pulse.
- Card handshake:
  - card_req rises on entry to a deal state and stays high until the cycle in which card_ack=1.
  - card_val is sampled in that cycle. card_req is 0 on the next cycle.
  - card_ack while card_req=0 is ignored.
- Card value normalisation: 0 is treated as 1; 11..15 saturate to 10.
- Hand arithmetic:
  - Each hand keeps a hard sum (aces counted as 1) and an ace flag.
  - Effective total = hard+10 if ace flag set and hard <= 11; otherwise hard.
  - phand/dhand show the effective total and update the cycle after the ack.
  - Player hard sum is <= 30 and dealer hard sum is <= 26, so no overflow is possible at HAND_W=5.
- States and transitions:
  - IDLE: enter press → clear hands and result → DEAL_P1.
  - DEAL_P1 (player) → DEAL_D1 (dealer) → DEAL_P2 (player). Each state advances on ack.
  - After DEAL_P2: player effective==21 → DEALER; otherwise → PLAYER.
  - PLAYER:
    - enter press → P_HIT.
    - pass press → DEALER.
    - Simultaneous enter and pass: enter wins.
  - P_HIT: on ack add the card, then:
    - effective > 21 → RESOLVE.
    - effective == 21 → DEALER.
    - otherwise → PLAYER.
  - DEALER: dealer effective < DEALER_STAND → D_HIT; otherwise → RESOLVE.
  - D_HIT: on ack add the card → DEALER.
  - RESOLVE (one cycle), then → DONE:
    - player bust → 10.
    - dealer bust → 01.
    - p > d → 01.
    - p < d → 10.
    - equal → 11.
  - DONE: result held. enter press → clear → DEAL_P1. pass is ignored.
- Button presses in any deal, hit or resolve state are discarded. They are not queued.
- card_to_dealer is valid whenever card_req=1; it is 1 in DEAL_D1 and D_HIT.
- Reset mid-handshake drops card_req in the same cycle (asynchronously). A later ack is ignored.
- Latency: a press is seen by the FSM 3 cycles after the pin falls (2 sync + 1 edge). The first card_req follows 1 cycle later.

Decomposition:
- Shared package: state encodings (IDLE=0, DEAL_P1, DEAL_D1, DEAL_P2, PLAYER, P_HIT, DEALER, D_HIT, RESOLVE, DONE), result codes, and TARGET/DEALER_STAND constants.
- One sub-module, button_edge_sync: 2-FF synchroniser plus falling-edge pulse. It is instantiated twice, for enter_n and pass_n.
- Hand add/soft-ace logic is written inline as a function used for both hands.

Test Plan:
- Reset during DEAL_D1 with card_req=1 → card_req=0 immediately, state_out=IDLE, phand=dhand=0; an ack then leaves the hands unchanged.
- Deal 10,6,1 (P,D,P) → phand=21 after DEAL_P2, PLAYER is skipped. Dealer draws 10 → dhand=16, draws 5 → dhand=21 → result=11 (push).
- Deal 9,10,7; hit with 3 → phand=19; pass. Dealer draws 8 → dhand=18 → result=01.
- Deal 10,5,6; hit with 9 → phand=25 → RESOLVE with no dealer draw → result=10, dhand=5.
- Ace softness: dealer deal 1, then draws 6 → dhand=17, dealer stands. Dealer 1,5,10 → dhand goes 16→16 (hard), then the dealer draws again.
- Hold enter low for 20 cycles in PLAYER → exactly one hit. Press enter and pass in the same cycle → hit taken, stand ignored. Ack delayed 5 cycles → card_req held high throughout.
